// File: rtl/uart_tx_param_if.sv
// Producer-to-UART valid/ready word channel.
// The master drives the word and valid; the slave (the transmitter) drives ready.
`timescale 1ns/1ps

interface uart_tx_param_if #(
  parameter int unsigned DATA_BITS = 8
) ();

  logic                 s_valid;
  logic                 s_ready;
  logic [DATA_BITS-1:0] s_data;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );

endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: one word per valid/ready handshake, serialised LSB first
// as start, data, optional parity and 1-2 stop bits on a registered, idle-high tx line.
`timescale 1ns/1ps

module uart_tx_param #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic           clock,
  input  logic           reset_n,
  uart_tx_param_if.slave s_bus,
  output logic           tx,
  output logic           busy
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
    $error("uart_tx_param: CLKS_PER_BIT=%0d outside 2..65535", CLKS_PER_BIT);
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS=%0d outside 5..9", DATA_BITS);
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY=%0d must be 0, 1 or 2", PARITY);
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS=%0d must be 1 or 2", STOP_BITS);
  end

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // One counter serves both the data bits and the stop bits, so size it for the larger.
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              ODD_PAR   = (PARITY == 1);
  localparam logic              HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  baud_wrap;
  logic                  accept;

  assign baud_wrap     = (baud_q == BAUD_LAST);
  assign s_bus.s_ready = (state_q == S_IDLE);
  assign accept        = s_bus.s_valid && (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign tx            = tx_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;

    if (state_q != S_IDLE) begin
      baud_d = baud_wrap ? '0 : baud_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (accept) begin
          // Parity is frozen from the captured word; the shift register is consumed later.
          shift_d = s_bus.s_data;
          par_d   = (^s_bus.s_data) ^ ODD_PAR;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_wrap) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_wrap) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (baud_wrap) begin
          bit_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_wrap) begin
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line level follows the current state; the register adds the one-cycle launch latency.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_q[0];
      S_PARITY: tx_d = par_q;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: five instances with different parameter sets,
// each frame compared cycle by cycle against a bit-list model built from the frame rules.
`timescale 1ns/1ps

module tb_uart_tx_param;

  localparam int N_DUT = 5;

  // 0: 8N1 fast, 1: 8E1, 2: 8O1, 3: 7N2, 4: 8N1 at 868 clocks per bit
  function automatic int cpb_of(input int i);
    return (i == 4) ? 868 : 4;
  endfunction
  function automatic int db_of(input int i);
    return (i == 3) ? 7 : 8;
  endfunction
  function automatic int par_of(input int i);
    return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
  endfunction
  function automatic int sb_of(input int i);
    return (i == 3) ? 2 : 1;
  endfunction

  logic              clock = 1'b0;
  logic              reset_n;
  logic [N_DUT-1:0]  s_valid_a;
  logic [8:0]        s_data_a [N_DUT];
  wire  [N_DUT-1:0]  s_ready_a;
  wire  [N_DUT-1:0]  tx_a;
  wire  [N_DUT-1:0]  busy_a;

  int   n_checks = 0;
  int   n_fails  = 0;
  logic exp_q[$];

  always #5 clock = ~clock;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    uart_tx_param_if #(.DATA_BITS(db_of(g))) bus ();

    assign bus.s_valid    = s_valid_a[g];
    assign bus.s_data     = s_data_a[g][db_of(g)-1:0];
    assign s_ready_a[g]   = bus.s_ready;

    if (db_of(g) < 9) begin : g_sink
      wire unused_hi = ^s_data_a[g][8:db_of(g)];
    end

    uart_tx_param #(
      .CLKS_PER_BIT(cpb_of(g)),
      .DATA_BITS   (db_of(g)),
      .PARITY      (par_of(g)),
      .STOP_BITS   (sb_of(g))
    ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .s_bus  (bus),
      .tx     (tx_a[g]),
      .busy   (busy_a[g])
    );
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required end of test before 2 ms");
    $fatal(1, "watchdog expired");
  end

  // Reference frame as a list of line levels, one per bit period.
  task automatic build_frame(input int idx, input logic [8:0] word);
    int ones;
    exp_q = {};
    ones  = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < db_of(idx); i++) begin
      exp_q.push_back(word[i]);
      ones += int'(word[i]);
    end
    if (par_of(idx) == 1) exp_q.push_back((ones % 2) == 0);
    if (par_of(idx) == 2) exp_q.push_back((ones % 2) == 1);
    for (int i = 0; i < sb_of(idx); i++) exp_q.push_back(1'b1);
  endtask

  // Call at a falling edge. Offers word, then checks every cycle of the frame.
  // abort_at > 0 pulses reset for one cycle at that frame cycle instead of finishing.
  task automatic drive_frame(input int idx, input logic [8:0] word, input bit hold,
                             input int abort_at, output int waited);
    int cpb, len, busy_cnt;
    logic exp_tx;
    build_frame(idx, word);
    cpb      = cpb_of(idx);
    len      = exp_q.size() * cpb;
    busy_cnt = 0;
    s_valid_a[idx] = 1'b1;
    s_data_a[idx]  = word;
    waited = 0;
    while (s_ready_a[idx] !== 1'b1 && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    if (s_ready_a[idx] !== 1'b1) begin
      n_checks++;
      n_fails++;
      $display("FAIL handshake_timeout dut%0d: s_ready=%b, required 1 within 100 cycles",
               idx, s_ready_a[idx]);
      s_valid_a[idx] = 1'b0;
      return;
    end
    @(posedge clock);
    @(negedge clock);
    n_checks++;
    if ({tx_a[idx], busy_a[idx], s_ready_a[idx]} !== 3'b110) begin
      n_fails++;
      $display("FAIL accept_edge dut%0d word=%h: tx/busy/s_ready=%b%b%b, required 110",
               idx, word, tx_a[idx], busy_a[idx], s_ready_a[idx]);
    end
    if (busy_a[idx] === 1'b1) busy_cnt++;
    s_valid_a[idx] = hold ? 1'b1 : 1'($urandom);
    s_data_a[idx]  = 9'($urandom);
    for (int c = 1; c <= len; c++) begin
      @(negedge clock);
      exp_tx = exp_q[(c - 1) / cpb];
      n_checks++;
      if (tx_a[idx] !== exp_tx) begin
        n_fails++;
        $display("FAIL tx_bit dut%0d word=%h cycle=%0d: tx=%b, required %b",
                 idx, word, c, tx_a[idx], exp_tx);
      end
      n_checks++;
      if (s_ready_a[idx] !== (c == len) || busy_a[idx] !== (c != len)) begin
        n_fails++;
        $display("FAIL handshake_flags dut%0d cycle=%0d: s_ready=%b busy=%b, required %b %b",
                 idx, c, s_ready_a[idx], busy_a[idx], c == len, c != len);
      end
      if (busy_a[idx] === 1'b1) busy_cnt++;
      if (c == abort_at) begin
        reset_n = 1'b0;
        s_valid_a[idx] = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        n_checks++;
        if ({tx_a[idx], s_ready_a[idx], busy_a[idx]} !== 3'b110) begin
          n_fails++;
          $display("FAIL reset_abort dut%0d: tx/s_ready/busy=%b%b%b, required 110",
                   idx, tx_a[idx], s_ready_a[idx], busy_a[idx]);
        end
        return;
      end
      if (c < len) begin
        s_valid_a[idx] = hold ? 1'b1 : 1'($urandom);
        s_data_a[idx]  = 9'($urandom);
      end else begin
        s_valid_a[idx] = hold;
      end
    end
    n_checks++;
    if (busy_cnt != len) begin
      n_fails++;
      $display("FAIL busy_length dut%0d: busy cycles=%0d, required %0d", idx, busy_cnt, len);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    s_valid_a = '0;
    for (int i = 0; i < N_DUT; i++) s_data_a[i] = 9'($urandom);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    for (int i = 0; i < N_DUT; i++) begin
      n_checks++;
      if ({tx_a[i], s_ready_a[i], busy_a[i]} !== 3'b110) begin
        n_fails++;
        $display("FAIL reset_state dut%0d: tx/s_ready/busy=%b%b%b, required 110",
                 i, tx_a[i], s_ready_a[i], busy_a[i]);
      end
    end
  endtask

  task automatic test_basic_8n1();
    int w;
    drive_frame(0, 9'h0A5, 1'b0, 0, w);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      drive_frame(0, 9'($urandom), 1'b0, 0, w);
    end
  endtask

  task automatic test_parity();
    int w;
    drive_frame(1, 9'h007, 1'b0, 0, w);
    drive_frame(2, 9'h007, 1'b0, 0, w);
    for (int k = 0; k < 4; k++) begin
      drive_frame(1, 9'($urandom), 1'b0, 0, w);
      drive_frame(2, 9'($urandom), 1'b0, 0, w);
    end
  endtask

  task automatic test_stop_bits();
    int w;
    drive_frame(3, 9'h07F, 1'b1, 0, w);
    drive_frame(3, 9'($urandom), 1'b0, 0, w);
    n_checks++;
    if (w != 0) begin
      n_fails++;
      $display("FAIL two_stop_gap dut3: waited=%0d cycles, required 0", w);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    logic [8:0] words [3];
    words[0] = 9'h001;
    words[1] = 9'h002;
    words[2] = 9'h003;
    for (int k = 0; k < 3; k++) begin
      drive_frame(0, words[k], k < 2, 0, w);
      if (k > 0) begin
        n_checks++;
        if (w != 0) begin
          n_fails++;
          $display("FAIL back_to_back_gap dut0 frame=%0d: waited=%0d, required 0", k, w);
        end
      end
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      n_checks++;
      if (tx_a[0] !== 1'b1 || busy_a[0] !== 1'b0) begin
        n_fails++;
        $display("FAIL single_accept dut0 cycle=%0d: tx=%b busy=%b, required 1 0",
                 c, tx_a[0], busy_a[0]);
      end
    end
    for (int k = 0; k < 3; k++) drive_frame(1, 9'($urandom), k < 2, 0, w);
  endtask

  task automatic test_reset_mid_frame();
    int w;
    // Third data bit occupies frame cycles 13..16 at four clocks per bit.
    drive_frame(0, 9'($urandom), 1'b0, 14, w);
    drive_frame(0, 9'h0C3, 1'b0, 0, w);
    n_checks++;
    if (w != 0) begin
      n_fails++;
      $display("FAIL post_reset_ready dut0: waited=%0d, required 0", w);
    end
  endtask

  task automatic test_long_baud();
    int w;
    drive_frame(4, 9'h055, 1'b0, 0, w);
    drive_frame(4, 9'($urandom), 1'b0, 0, w);
  endtask

  initial begin
    test_reset();
    test_basic_8n1();
    test_parity();
    test_stop_bits();
    test_back_to_back();
    test_reset_mid_frame();
    test_long_baud();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter that serialises one word per valid/ready handshake onto a single tx line. Baud divider, data width, parity mode and stop-bit count are set by parameters. It drives the board-level UART pin and is fed by a command/data producer (FIFO or control FSM) through a standard valid/ready interface.

Parameters:
CLKS_PER_BIT, 868, clock cycles per bit period (868 = 100 MHz / 115200); legal range 2..65535
DATA_BITS, 8, payload bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame; legal values 1 or 2

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous active-low reset
s_valid  in  1  producer has a word on s_data
s_ready  out  1  block can accept a word this cycle
s_data  in  DATA_BITS  word to transmit, LSB first
tx  out  1  serial line, idle high
busy  out  1  high from acceptance until the last stop-bit cycle completes

Behaviour:
- Reset: reset_n is synchronous and active-low, clocked on clock. It takes priority over everything else. Reset values: tx=1, s_ready=1, busy=0, state=IDLE, bit counter=0, baud counter=0. Reset in mid-frame aborts the frame. tx returns high on the next edge. No partial bits are completed.
- Handshake: a transfer occurs on a rising edge where s_valid && s_ready. s_data is captured into the shift register on that edge. s_ready=1 only in IDLE. It is deasserted on the accepting edge and held low for the whole frame. s_data and s_valid are don't-care while s_ready=0.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. On handshake go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first, DATA_BITS bits.
  - PARITY: entered only if PARITY!=0. tx=parity bit for CLKS_PER_BIT cycles.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE with s_ready=1 and busy=0.
- Latency: tx falls on the first edge after the accepting edge (registered output).
- Parity: odd sets the bit so the ones-count of data+parity is odd. Even sets it so the count is even. The parity bit is computed from the captured word, not from live s_data.
- Baud counter: width is clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. The bit counter advances only on wrap.
- Frame length: exactly (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles of non-idle tx, from the first start-bit cycle to the last stop-bit cycle.
- Back-to-back: if s_valid is held high, the next handshake occurs on the first IDLE cycle. This gives exactly 1 extra idle-high cycle between frames, which is allowed as stop-bit extension.
- busy rises on the accepting edge and falls on the same edge on which s_ready rises.
- Illegal parameter values must trigger a simulation-time $error at elaboration.

Test Plan:
1. CLKS_PER_BIT=4, DATA_BITS=8, PARITY=0, STOP_BITS=1; send 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. s_ready low for 40 cycles, then high.
2. PARITY=2 (even), send 0x07 -> parity bit=1; PARITY=1 (odd), send 0x07 -> parity bit=0. Frame is 11 bit periods.
3. STOP_BITS=2, DATA_BITS=7, send 0x7F -> 7 ones after the start bit, then 8 high cycles. Next start bit no earlier than 1 cycle after that.
4. s_valid held high with words 0x01, 0x02, 0x03 -> three contiguous frames, each gap exactly 1 idle cycle. Each word is accepted once. Changing s_data mid-frame does not alter the bits on tx.
5. Assert reset_n=0 for 1 cycle during the 3rd data bit -> tx=1, s_ready=1, busy=0 on the next edge. A new handshake afterwards produces a clean full frame.
6. CLKS_PER_BIT=868, 8N1, send 0x55 -> each bit period measured as exactly 868 cycles. Total frame is 8680 cycles.
